// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp, R-type funct codes,
// forwarding selects and the multiplier sequencing state.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // state | meaning
    // IDLE  | no multiply in flight; a new mul captures operands here
    // RUN   | one shift-add step per unstalled cycle
    // DONE  | product ready; EX/MEM loads it while ID/EX advances
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b,
// one partial product per step; done_o flags the final step.
module mul_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] prod_o
);

    localparam int            CW   = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            // Low-half product only, so two's complement operands need no correction.
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign done_o = step_i && (cnt_q == LAST);
    assign prod_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU and the EX/MEM register. Defining
// EX_STAGE_MUL_EN adds the iterative multiplier and its busy_o sequencing.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] regA_i,
    input  logic [XLEN-1:0] regB_i,
    input  logic [XLEN-1:0] immidiate_i,
    input  logic [1:0]      ALUOp_i,
    input  logic            ALUSrc_i,
    input  logic            RegDst_i,
    input  logic            RegWrite_i,
    input  logic            MemtoReg_i,
    input  logic            MemWrite_i,
    input  logic            MemRead_i,
    input  logic [4:0]      RegistersRT_i,
    input  logic [4:0]      RegistersRD_i,
    input  logic [1:0]      fwdA_i,
    input  logic [1:0]      fwdB_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic [XLEN-1:0] memwb_data_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [4:0]      wreg_o,
    output logic            RegWrite_o,
    output logic            MemtoReg_o,
    output logic            MemWrite_o,
    output logic            MemRead_o,
    output logic            busy_o
);

    if (MUL_CYCLES != XLEN) begin : g_bad_cfg
        $error("ex_stage: MUL_CYCLES must equal XLEN");
    end

    logic [5:0]      funct;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_result;
    logic            busy;

    assign funct = immidiate_i[5:0];

    always_comb begin
        op_a = regA_i;
        case (fwdA_i)
            FWD_EXMEM: op_a = exmem_data_i;
            FWD_MEMWB: op_a = memwb_data_i;
            default:   op_a = regA_i;
        endcase
    end

    always_comb begin
        fwd_b = regB_i;
        case (fwdB_i)
            FWD_EXMEM: fwd_b = exmem_data_i;
            FWD_MEMWB: fwd_b = memwb_data_i;
            default:   fwd_b = regB_i;
        endcase
    end

    assign op_b = ALUSrc_i ? immidiate_i : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ALUOp_i)
            ALUOP_ADD, ALUOP_ADDI: alu_res = op_a + op_b;
            ALUOP_SUB:             alu_res = op_a - op_b;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_res = op_a + op_b;
                    FUNCT_SUB: alu_res = op_a - op_b;
                    FUNCT_AND: alu_res = op_a & op_b;
                    FUNCT_OR:  alu_res = op_a | op_b;
                    // The product, when built in, is muxed in after the ALU.
                    FUNCT_MUL: alu_res = '0;
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_STAGE_MUL_EN
    mul_state_e      state_q;
    logic            is_mul;
    logic            mul_start;
    logic            mul_step;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign is_mul    = (ALUOp_i == ALUOP_RTYPE) && (funct == FUNCT_MUL);
    // Reset forces busy low so a held mul on ID/EX cannot assert it before release.
    assign busy      = rst_n_i && is_mul && (state_q != MUL_DONE);
    assign mul_start = !stall_i && is_mul && (state_q == MUL_IDLE);
    assign mul_step  = !stall_i && (state_q == MUL_RUN);

    mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_iter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (mul_start),
        .step_i  (mul_step),
        .a_i     (op_a),
        .b_i     (fwd_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MUL_IDLE;
        end else if (!stall_i) begin
            case (state_q)
                MUL_IDLE: if (is_mul)   state_q <= MUL_RUN;
                MUL_RUN:  if (mul_done) state_q <= MUL_DONE;
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end

    assign ex_result = ((state_q == MUL_DONE) && is_mul) ? mul_prod : alu_res;
`else
    assign busy      = 1'b0;
    assign ex_result = alu_res;
`endif

    assign busy_o = busy;

    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      wreg_q, wreg_d;
    logic            regwrite_q, regwrite_d;
    logic            memtoreg_q, memtoreg_d;
    logic            memwrite_q, memwrite_d;
    logic            memread_q, memread_d;

    always_comb begin
        result_d   = result_q;
        wdata_d    = wdata_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memwrite_d = memwrite_q;
        memread_d  = memread_q;
        if (busy) begin
            // Bubble: kill side effects, keep data fields stable.
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else begin
            result_d   = ex_result;
            wdata_d    = fwd_b;
            wreg_d     = RegDst_i ? RegistersRD_i : RegistersRT_i;
            regwrite_d = RegWrite_i;
            memtoreg_d = MemtoReg_i;
            memwrite_d = MemWrite_i;
            memread_d  = MemRead_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_q   <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else if (!stall_i) begin
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
            memread_q  <= memread_d;
        end
    end

    assign alu_result_o = result_q;
    assign wdata_o      = wdata_q;
    assign wreg_o       = wreg_q;
    assign RegWrite_o   = regwrite_q;
    assign MemtoReg_o   = memtoreg_q;
    assign MemWrite_o   = memwrite_q;
    assign MemRead_o    = memread_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;

`ifdef EX_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stall_i;
    logic [31:0] regA_i, regB_i, immidiate_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i;
    logic [4:0]  RegistersRT_i, RegistersRD_i;
    logic [1:0]  fwdA_i, fwdB_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic [31:0] alu_result_o, wdata_o;
    logic [4:0]  wreg_o;
    logic        RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o, busy_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_res, exp_wdata;
    logic [4:0]  exp_wreg;
    logic        exp_rw, exp_m2r, exp_mw, exp_mr;

    ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .stall_i       (stall_i),
        .regA_i        (regA_i),
        .regB_i        (regB_i),
        .immidiate_i   (immidiate_i),
        .ALUOp_i       (ALUOp_i),
        .ALUSrc_i      (ALUSrc_i),
        .RegDst_i      (RegDst_i),
        .RegWrite_i    (RegWrite_i),
        .MemtoReg_i    (MemtoReg_i),
        .MemWrite_i    (MemWrite_i),
        .MemRead_i     (MemRead_i),
        .RegistersRT_i (RegistersRT_i),
        .RegistersRD_i (RegistersRD_i),
        .fwdA_i        (fwdA_i),
        .fwdB_i        (fwdB_i),
        .exmem_data_i  (exmem_data_i),
        .memwb_data_i  (memwb_data_i),
        .alu_result_o  (alu_result_o),
        .wdata_o       (wdata_o),
        .wreg_o        (wreg_o),
        .RegWrite_o    (RegWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .MemWrite_o    (MemWrite_o),
        .MemRead_o     (MemRead_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fwd_val(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'b10) return exmem_data_i;
        if (s == 2'b01) return memwb_data_i;
        return r;
    endfunction

    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h18:   return MUL_EN ? a * b : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_load();
        logic [31:0] a, bf, b;
        logic [31:0] imm;
        imm       = immidiate_i;
        a         = fwd_val(fwdA_i, regA_i);
        bf        = fwd_val(fwdB_i, regB_i);
        b         = ALUSrc_i ? imm : bf;
        exp_res   = model_alu(ALUOp_i, imm[5:0], a, b);
        exp_wdata = bf;
        exp_wreg  = RegDst_i ? RegistersRD_i : RegistersRT_i;
        exp_rw    = RegWrite_i;
        exp_m2r   = MemtoReg_i;
        exp_mw    = MemWrite_i;
        exp_mr    = MemRead_i;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".res"},   alu_result_o,      exp_res);
        chk({tag, ".wdata"}, wdata_o,           exp_wdata);
        chk({tag, ".wreg"},  32'(wreg_o),       32'(exp_wreg));
        chk({tag, ".rw"},    32'(RegWrite_o),   32'(exp_rw));
        chk({tag, ".m2r"},   32'(MemtoReg_o),   32'(exp_m2r));
        chk({tag, ".mw"},    32'(MemWrite_o),   32'(exp_mw));
        chk({tag, ".mr"},    32'(MemRead_o),    32'(exp_mr));
    endtask

    task automatic clear_exp();
        exp_res = '0; exp_wdata = '0; exp_wreg = '0;
        exp_rw = 1'b0; exp_m2r = 1'b0; exp_mw = 1'b0; exp_mr = 1'b0;
    endtask

    task automatic set_nop();
        regA_i = '0; regB_i = '0; immidiate_i = '0; ALUOp_i = 2'b00;
        ALUSrc_i = 1'b0; RegDst_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
        MemWrite_i = 1'b0; MemRead_i = 1'b0; RegistersRT_i = '0; RegistersRD_i = '0;
        fwdA_i = 2'b00; fwdB_i = 2'b00; exmem_data_i = '0; memwb_data_i = '0;
    endtask

    // Inputs already driven; checks busy, clocks once, checks EX/MEM.
    task automatic step_op(input string tag);
        #1;
        chk({tag, ".busy"}, 32'(busy_o), 32'h0);
        if (!stall_i) model_load();
        @(posedge clk_i); #1;
        check_outputs(tag);
    endtask

    task automatic random_op();
        logic [31:0] r;
        logic [5:0]  f;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       f = 6'h20;
            1:       f = 6'h22;
            2:       f = 6'h24;
            3:       f = 6'h25;
            4:       f = 6'h18;
            default: f = r[5:0];
        endcase
        ALUOp_i = 2'($urandom_range(0, 3));
        if (MUL_EN && ALUOp_i == 2'b10 && f == 6'h18) f = 6'h20;
        immidiate_i   = {r[31:6], f};
        regA_i        = $urandom;
        regB_i        = $urandom;
        exmem_data_i  = $urandom;
        memwb_data_i  = $urandom;
        fwdA_i        = 2'($urandom_range(0, 3));
        fwdB_i        = 2'($urandom_range(0, 3));
        ALUSrc_i      = 1'($urandom_range(0, 1));
        RegDst_i      = 1'($urandom_range(0, 1));
        RegWrite_i    = 1'($urandom_range(0, 1));
        MemtoReg_i    = 1'($urandom_range(0, 1));
        MemWrite_i    = 1'($urandom_range(0, 1));
        MemRead_i     = 1'($urandom_range(0, 1));
        RegistersRT_i = 5'($urandom_range(0, 31));
        RegistersRD_i = 5'($urandom_range(0, 31));
    endtask

`ifdef EX_STAGE_MUL_EN
    // Mul with A from EX/MEM and B from MEM/WB; both sources change mid-run.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len);
        logic [31:0] expp;
        logic [31:0] r;
        int n;
        expp = a * b;
        n    = 34 + stall_len;
        r    = $urandom;
        set_nop();
        ALUOp_i       = 2'b10;
        immidiate_i   = {r[31:6], 6'h18};
        fwdA_i        = 2'b10;
        exmem_data_i  = a;
        regA_i        = ~a;
        fwdB_i        = 2'b01;
        memwb_data_i  = b;
        regB_i        = ~b;
        RegWrite_i    = 1'b1;
        RegDst_i      = 1'b1;
        RegistersRD_i = 5'($urandom_range(1, 31));
        for (int k = 0; k < n; k++) begin
            stall_i = (k >= stall_at) && (k < stall_at + stall_len);
            if (k == 10) begin
                exmem_data_i = a ^ 32'h5A5A_0F0F;
                memwb_data_i = b + 32'd77;
            end
            #1;
            chk({tag, ".busy"}, 32'(busy_o), 32'(k < n - 1));
            if (k == n - 1) begin
                model_load();
                exp_res = expp;
            end else if (!stall_i) begin
                exp_rw = 1'b0; exp_mw = 1'b0; exp_mr = 1'b0;
            end
            @(posedge clk_i); #1;
            check_outputs(tag);
        end
        stall_i = 1'b0;
        set_nop();
    endtask
`endif

    initial begin
        stall_i = 1'b0;
        set_nop();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        clear_exp();
        check_outputs("reset");
        chk("reset.busy", 32'(busy_o), 32'h0);
`ifdef EX_STAGE_MUL_EN
        ALUOp_i = 2'b10; immidiate_i = 32'h18; #1;
        chk("reset.busy_mul", 32'(busy_o), 32'h0);
        set_nop();
`endif
        rst_n_i = 1'b1;

        set_nop();
        ALUOp_i = 2'b10; immidiate_i = 32'h20; regA_i = 32'h7FFF_FFFF; regB_i = 32'h1;
        RegWrite_i = 1'b1; RegDst_i = 1'b1; RegistersRD_i = 5'd9; RegistersRT_i = 5'd3;
        step_op("add_wrap");
        chk("add_wrap.const", alu_result_o, 32'h8000_0000);
        chk("add_wrap.wreg",  32'(wreg_o), 32'd9);

        set_nop();
        ALUOp_i = 2'b10; immidiate_i = 32'h22; regA_i = 32'd9; regB_i = 32'd2;
        fwdA_i = 2'b10; exmem_data_i = 32'd5; RegWrite_i = 1'b1;
        step_op("fwd_exmem");
        chk("fwd_exmem.const", alu_result_o, 32'd3);
        fwdA_i = 2'b01; memwb_data_i = 32'd4;
        step_op("fwd_memwb");
        chk("fwd_memwb.const", alu_result_o, 32'd2);

        set_nop();
        ALUOp_i = 2'b00; ALUSrc_i = 1'b1; immidiate_i = 32'd8; regA_i = 32'h100;
        fwdB_i = 2'b10; exmem_data_i = 32'hAB; regB_i = 32'h55; MemWrite_i = 1'b1;
        RegistersRT_i = 5'd7;
        step_op("store");
        chk("store.const_res", alu_result_o, 32'h108);
        chk("store.const_wd",  wdata_o, 32'hAB);
        chk("store.const_mw",  32'(MemWrite_o), 32'h1);

        set_nop();
        ALUOp_i = 2'b10; immidiate_i = 32'h18; regA_i = 32'd7; regB_i = 32'd3;
        RegWrite_i = 1'b1;
`ifndef EX_STAGE_MUL_EN
        step_op("mul_off");
        chk("mul_off.const", alu_result_o, 32'h0);
`endif

        set_nop();
        ALUOp_i = 2'b01; regA_i = 32'd100; regB_i = 32'd1; RegWrite_i = 1'b1;
        stall_i = 1'b1;
        step_op("stall_hold");
        stall_i = 1'b0;
        step_op("stall_release");

        for (int i = 0; i < 200; i++) begin
            random_op();
            stall_i = ($urandom_range(0, 4) == 0);
            step_op("rand");
        end
        stall_i = 1'b0;

        random_op();
        rst_n_i = 1'b0;
        #1;
        clear_exp();
        check_outputs("rst_mid");
        chk("rst_mid.busy", 32'(busy_o), 32'h0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

`ifdef EX_STAGE_MUL_EN
        run_mul("mul_basic", 32'd7, 32'hFFFF_FFFD, 1000, 0);
        chk("mul_basic.const", alu_result_o, 32'hFFFF_FFEB);
        run_mul("mul_b2b", 32'($urandom), 32'($urandom), 1000, 0);
        run_mul("mul_stall", 32'($urandom), 32'($urandom), 10, 5);

        set_nop();
        ALUOp_i = 2'b10; immidiate_i = 32'h18; fwdA_i = 2'b10; exmem_data_i = 32'd6;
        regB_i = 32'd11; RegWrite_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        clear_exp();
        check_outputs("mul_rst");
        chk("mul_rst.busy", 32'(busy_o), 32'h0);
        set_nop();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            random_op();
            step_op("after_rst");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined CPU, sitting between the ID/EX pipeline register and the data-cache MEM stage. It consumes the ID/EX operands and control bits, applies forwarding, decodes ALU control and computes the result. It registers everything into the EX/MEM boundary. An optional iterative 32-cycle multiplier holds the front of the pipeline through `busy_o` until its product is ready.

## Interface
- `XLEN`, 32: datapath width
- `MUL_CYCLES`, 32: multiplier iterations; must equal `XLEN`
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `stall_i`  in  1  dcache stall; freezes this block completely
- `regA_i`, `regB_i`  in  32  register operands from ID/EX
- `immidiate_i`  in  32  sign-extended immediate; bits [5:0] are funct
- `ALUOp_i`  in  2  00 add, 01 sub, 10 R-type by funct, 11 add (addi)
- `ALUSrc_i`, `RegDst_i`, `RegWrite_i`, `MemtoReg_i`, `MemWrite_i`, `MemRead_i`  in  1 each  ID/EX control
- `RegistersRT_i`, `RegistersRD_i`  in  5 each  destination candidates
- `fwdA_i`, `fwdB_i`  in  2 each  forwarding select: 00 register, 10 EX/MEM, 01 MEM/WB
- `exmem_data_i`, `memwb_data_i`  in  32 each  forwarded values
- `alu_result_o`  out  32  registered ALU/product result
- `wdata_o`  out  32  registered forwarded B operand, used as the store data
- `wreg_o`  out  5  registered destination: RD if `RegDst_i`, else RT
- `RegWrite_o`, `MemtoReg_o`, `MemWrite_o`, `MemRead_o`  out  1 each  registered control
- `busy_o`  out  1  combinational; ID/EX and earlier stages must hold while high

## Operation
- Operand A is `regA_i`, `exmem_data_i` or `memwb_data_i`, selected by `fwdA_i`. Select 11 behaves as 00.
- Operand B is selected by `fwdB_i` in the same way. When `ALUSrc_i` is set, `immidiate_i` replaces operand B; `wdata_o` always takes the forwarded B value.
- R-type funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 011000 mul (low 32 bits). Any other funct gives result 0.
- Add and sub are modulo 2^32; there is no overflow trap.
- Multiplier FSM states:
  - IDLE: a mul arriving with `stall_i` low raises `busy_o` combinationally. At the clock edge the forwarded operands are captured, the counter is cleared, and the FSM moves to RUN.
  - RUN: one shift-add step per unstalled cycle. After the step at counter = `MUL_CYCLES`-1, the FSM moves to DONE. `busy_o` stays high throughout RUN.
  - DONE: `busy_o` is low. The EX/MEM register captures the product and the mul's control bits while ID/EX advances on the same edge. The FSM then returns to IDLE.
- Operands are captured once, in IDLE, because the forwarding sources change while bubbles drain.
- While `busy_o` is high and `stall_i` is low, the EX/MEM register loads a bubble: `RegWrite_o`, `MemWrite_o` and `MemRead_o` go to 0, and the data fields are don't-care but deterministic (held).
- While `stall_i` is high, the EX/MEM register and all FSM/counter state hold.
- `stall_i` has priority over FSM advance.

## Timing
- Reset: every output is 0, the FSM is in IDLE, the counter is 0, and `busy_o` is 0.
- Reset asserted mid-multiply aborts the operation. No result is ever written for it.
- Non-mul ops: result appears on the EX/MEM outputs one edge after the inputs are presented, with `stall_i` low.
- Mul with no stalls: one IDLE cycle plus 32 RUN cycles plus one DONE cycle. The result is visible after the 34th edge.
- A second, back-to-back mul seen in DONE is not restarted, since ID/EX has not advanced yet. It is taken from IDLE on the next cycle.
- `busy_o` depends combinationally on `ALUOp_i`/funct and the FSM state. It has no dependency on `stall_i`.

## Configuration
- `EX_STAGE_MUL_EN` defined: the multiplier FSM and submodule are compiled in.
- Macro undefined: funct 011000 decodes as unknown (result 0), `busy_o` is tied 0, and no FSM or counter exists.

## Structure
- Package `ex_pkg` holds:
  - the ALUOp encodings
  - the funct constants
  - the forwarding-select constants
  - the FSM state typedef (IDLE/RUN/DONE)
- Submodule `mul_iter`: shift-add core with start, step-enable, done, and a 32-bit low product.
- `ex_stage` owns the forwarding muxes, the ALU, the FSM sequencing and the EX/MEM register.

## Test plan
- ALUOp 10, funct add, A=0x7FFFFFFF, B=1 → `alu_result_o`=0x80000000 after 1 edge, `RegWrite_o`=1.
- `fwdA_i`=10, `exmem_data_i`=5, `regA_i`=9, funct sub, B=2 → result 3. Repeat with `fwdA_i`=01, `memwb_data_i`=4 → result 2.
- sw with `ALUSrc_i`=1, imm=8, A=0x100, `fwdB_i`=10, `exmem_data_i`=0xAB → result 0x108, `wdata_o`=0xAB, `MemWrite_o`=1.
- mul 7×(−3) → `busy_o` high for 33 cycles, with `RegWrite_o`=0 bubbles during that time. 0xFFFFFFEB appears after edge 34; `exmem_data_i` toggling mid-run does not affect the result.
- `stall_i` high for 5 cycles mid-RUN → result delayed exactly 5 cycles and outputs held. Reset pulse mid-RUN → all outputs 0 and `busy_o`=0 immediately.
- Macro off: mul funct → result 0 after 1 edge, and `busy_o` never asserts.
